// File: rtl/mem_phase_ctrl_if.sv
// Data-memory port bundle shared by the phase controller (master) and the RAM (slave).
interface mem_phase_ctrl_if #(
    parameter int unsigned ADDR_W = 16
) ();
    localparam int unsigned DATA_W = 8;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_we, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_phase_ctrl.sv
// Phase sequencer for the image processor: LOAD (UART -> RAM), RUN (core owns RAM),
// DUMP (RAM -> UART). Owns the single data-memory port and muxes it per phase.
module mem_phase_ctrl #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] LOAD_BASE = ADDR_W'(16'h0000),
    parameter logic [ADDR_W-1:0] LOAD_LEN  = ADDR_W'(16'd256),
    parameter logic [ADDR_W-1:0] DUMP_BASE = ADDR_W'(16'h0100),
    parameter logic [ADDR_W-1:0] DUMP_LEN  = ADDR_W'(16'd64)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              receive,
    input  logic              send,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              cpu_en,
    input  logic              cpu_done,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    mem_phase_ctrl_if.master  mem,
    output logic [1:0]        phase,
    output logic              rx_LED,
    output logic              tx_LED
);
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RUN       = 3'd2,
        S_DUMP_ADDR = 3'd3,
        S_DUMP_CAP  = 3'd4,
        S_DUMP_TX   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              receive_q, send_q;
    logic              receive_edge, send_edge;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] tx_data_d;

    // Externally visible phase code; the three dump sub-states all report DUMP.
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_LOAD:                            phase_of = 2'd1;
            S_RUN:                             phase_of = 2'd2;
            S_DUMP_ADDR, S_DUMP_CAP, S_DUMP_TX: phase_of = 2'd3;
            default:                           phase_of = 2'd0;
        endcase
    endfunction

    // Rising-edge detect on the start requests.
    assign receive_edge = receive & ~receive_q;
    assign send_edge    = send & ~send_q;

    // Next-state, counter and memory-port mux; address/data hold their last value when idle.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        tx_data_d     = tx_data;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (receive_edge) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end else if (send_edge) begin
                    state_d = S_DUMP_ADDR;
                    count_d = '0;
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    mem.mem_we    = 1'b1;
                    mem.mem_addr  = LOAD_BASE + count_q;
                    mem.mem_wdata = rx_data;
                    if (count_q == LOAD_LEN - ADDR_W'(1)) begin
                        state_d = S_RUN;
                        count_d = '0;
                    end else begin
                        count_d = count_q + ADDR_W'(1);
                    end
                end
            end
            S_RUN: begin
                mem.mem_we    = cpu_we;
                mem.mem_addr  = cpu_addr;
                mem.mem_wdata = cpu_wdata;
                if (cpu_done) begin
                    state_d = S_IDLE;
                end
            end
            S_DUMP_ADDR: begin
                mem.mem_addr = DUMP_BASE + count_q;
                state_d      = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                tx_data_d = mem.mem_rdata;
                state_d   = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                if (tx_valid && tx_ready) begin
                    if (count_q == DUMP_LEN - ADDR_W'(1)) begin
                        state_d = S_IDLE;
                        count_d = '0;
                    end else begin
                        state_d = S_DUMP_ADDR;
                        count_d = count_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, counter, request history and memory-port hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            receive_q <= 1'b0;
            send_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            receive_q <= receive;
            send_q    <= send;
            addr_q    <= mem.mem_addr;
            wdata_q   <= mem.mem_wdata;
        end
    end

    // Registered status/handshake outputs, aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            cpu_en   <= 1'b0;
            phase    <= 2'd0;
            rx_LED   <= 1'b0;
            tx_LED   <= 1'b0;
        end else begin
            tx_valid <= (state_d == S_DUMP_TX);
            tx_data  <= tx_data_d;
            cpu_en   <= (state_d == S_RUN);
            phase    <= phase_of(state_d);
            rx_LED   <= (state_d == S_LOAD);
            tx_LED   <= (phase_of(state_d) == 2'd3);
        end
    end
endmodule

// File: tb/tb_mem_phase_ctrl.sv
// Bench for mem_phase_ctrl: two instances (load base 0x0000 and 0xFFFE) driven by the same
// randomized stimulus, checked every cycle against a transaction-level model of the phases.
module tb_mem_phase_ctrl;
    localparam int unsigned ADDR_W = 16;
    localparam int LLEN  = 4;
    localparam int DLEN  = 4;
    localparam int DBASE = 'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        receive, send, rx_valid, tx_ready, cpu_done, cpu_we;
    logic [7:0]  rx_data, cpu_wdata;
    logic [15:0] cpu_addr;
    logic [1:0]  tx_valid, cpu_en, rx_led, tx_led;
    logic [7:0]  tx_data [2];
    logic [1:0]  phase [2];
    int          n_chk = 0;
    int          n_err = 0;

    mem_phase_ctrl_if #(.ADDR_W(ADDR_W)) mif0 ();
    mem_phase_ctrl_if #(.ADDR_W(ADDR_W)) mif1 ();

    mem_phase_ctrl #(.ADDR_W(ADDR_W), .LOAD_BASE(16'h0000), .LOAD_LEN(16'd4),
                     .DUMP_BASE(16'h0100), .DUMP_LEN(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .receive(receive), .send(send),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
        .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .cpu_en(cpu_en[0]),
        .cpu_done(cpu_done), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem(mif0), .phase(phase[0]), .rx_LED(rx_led[0]), .tx_LED(tx_led[0]));

    mem_phase_ctrl #(.ADDR_W(ADDR_W), .LOAD_BASE(16'hFFFE), .LOAD_LEN(16'd4),
                     .DUMP_BASE(16'h0100), .DUMP_LEN(16'd4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .receive(receive), .send(send),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
        .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .cpu_en(cpu_en[1]),
        .cpu_done(cpu_done), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem(mif1), .phase(phase[1]), .rx_LED(rx_led[1]), .tx_LED(tx_led[1]));

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int k);
        return 8'(8'h11 * (k + 1));
    endfunction

    // Synchronous RAMs; dump window reloaded with 11,22,33,44 while reset is held.
    logic [7:0] ram0 [65536];
    logic [7:0] ram1 [65536];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DLEN; k++) begin
                ram0[DBASE + k] <= init_byte(k);
                ram1[DBASE + k] <= init_byte(k);
            end
        end else begin
            if (mif0.mem_we) ram0[mif0.mem_addr] <= mif0.mem_wdata;
            if (mif1.mem_we) ram1[mif1.mem_addr] <= mif1.mem_wdata;
        end
        mif0.mem_rdata <= ram0[mif0.mem_addr];
        mif1.mem_rdata <= ram1[mif1.mem_addr];
    end

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 load, 2 run, 3 dump. In dump, step 0 = address out, 1 = data back, 2 = offered.
    int          m_mode, m_cnt, m_step;
    logic        m_prev_r, m_prev_s;
    logic [15:0] m_hold_a [2];
    logic [7:0]  m_hold_d [2];
    logic [7:0]  m_txd [2];
    logic [7:0]  shm [2][65536];
    logic [15:0] ma;
    logic [7:0]  md;

    function automatic int base_of(input int i);
        return (i == 0) ? 'h0000 : 'hFFFE;
    endfunction

    function automatic logic exp_we();
        return (m_mode == 1 && rx_valid) || (m_mode == 2 && cpu_we);
    endfunction

    function automatic logic [15:0] exp_addr(input int i);
        if (m_mode == 2) return cpu_addr;
        if (m_mode == 3 && m_step == 0) return 16'(DBASE + m_cnt);
        if (m_mode == 1 && rx_valid) return 16'(base_of(i) + m_cnt);
        return m_hold_a[i];
    endfunction

    function automatic logic [7:0] exp_wdata(input int i);
        if (m_mode == 2) return cpu_wdata;
        if (m_mode == 1 && rx_valid) return rx_data;
        return m_hold_d[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_step = 0;
            m_prev_r = 1'b0; m_prev_s = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_hold_a[i] = '0; m_hold_d[i] = '0; m_txd[i] = '0;
                for (int k = 0; k < DLEN; k++) shm[i][DBASE + k] = init_byte(k);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ma = exp_addr(i);
                md = exp_wdata(i);
                if (exp_we()) shm[i][ma] = md;
                m_hold_a[i] = ma;
                m_hold_d[i] = md;
            end
            case (m_mode)
                0: begin
                    if (receive && !m_prev_r) begin
                        m_mode = 1; m_cnt = 0;
                    end else if (send && !m_prev_s) begin
                        m_mode = 3; m_cnt = 0; m_step = 0;
                    end
                end
                1: if (rx_valid) begin
                    if (m_cnt == LLEN - 1) begin m_mode = 2; m_cnt = 0; end
                    else m_cnt++;
                end
                2: if (cpu_done) m_mode = 0;
                default: begin
                    if (m_step == 0) m_step = 1;
                    else if (m_step == 1) begin
                        for (int i = 0; i < 2; i++) m_txd[i] = shm[i][DBASE + m_cnt];
                        m_step = 2;
                    end else if (tx_ready) begin
                        if (m_cnt == DLEN - 1) m_mode = 0;
                        else begin m_cnt++; m_step = 0; end
                    end
                end
            endcase
            m_prev_r = receive;
            m_prev_s = send;
        end
    end

    task automatic chk(input int inst, input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (inst %0d) at %0t: got %0h want %0h", nm, inst, $time, got, exp);
        end
    endtask

    task automatic cmp_inst(input int i, input logic tv, input logic [7:0] td, input logic ce,
                            input logic [1:0] ph, input logic rl, input logic tl, input logic we,
                            input logic [15:0] a, input logic [7:0] wd);
        chk(i, "tx_valid",  32'(tv), 32'(m_mode == 3 && m_step == 2));
        chk(i, "tx_data",   32'(td), 32'(m_txd[i]));
        chk(i, "cpu_en",    32'(ce), 32'(m_mode == 2));
        chk(i, "phase",     32'(ph), 32'(m_mode));
        chk(i, "rx_LED",    32'(rl), 32'(m_mode == 1));
        chk(i, "tx_LED",    32'(tl), 32'(m_mode == 3));
        chk(i, "mem_we",    32'(we), 32'(exp_we()));
        chk(i, "mem_addr",  32'(a),  32'(exp_addr(i)));
        chk(i, "mem_wdata", 32'(wd), 32'(exp_wdata(i)));
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp_inst(0, tx_valid[0], tx_data[0], cpu_en[0], phase[0], rx_led[0], tx_led[0],
                 mif0.mem_we, mif0.mem_addr, mif0.mem_wdata);
        cmp_inst(1, tx_valid[1], tx_data[1], cpu_en[1], phase[1], rx_led[1], tx_led[1],
                 mif1.mem_we, mif1.mem_addr, mif1.mem_wdata);
    end

    // ---------------- stimulus ----------------
    logic [15:0] wrap_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_junk(input int n);
        for (int j = 0; j < n; j++) begin
            rx_valid  = 1'($urandom_range(1));
            rx_data   = 8'($urandom);
            cpu_we    = 1'($urandom_range(1));
            cpu_addr  = 16'($urandom);
            cpu_wdata = 8'($urandom);
            tx_ready  = 1'($urandom_range(1));
            settle();
            if (rx_valid) chk(0, "idle_rx_no_write", 32'(mif0.mem_we), 32'd0);
            cyc();
        end
        rx_valid = 1'b0; cpu_we = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic load_body(input logic [7:0] b [4], input bit lit, input bit done_on_last);
        for (int k = 0; k < LLEN; k++) begin
            for (int g = 0; g < int'($urandom_range(3)); g++) begin
                rx_valid = 1'b0; rx_data = 8'($urandom);
                cyc();
            end
            rx_valid = 1'b1; rx_data = b[k];
            if (done_on_last && k == LLEN - 1) cpu_done = 1'b1;
            settle();
            if (lit) begin
                chk(0, "load_we",        32'(mif0.mem_we),    32'd1);
                chk(0, "load_addr",      32'(mif0.mem_addr),  32'(k));
                chk(0, "load_wdata",     32'(mif0.mem_wdata), 32'(b[k]));
                chk(1, "load_wrap_addr", 32'(mif1.mem_addr),  32'(wrap_a[k]));
            end
            cyc();
            rx_valid = 1'b0;
        end
        chk(0, "load_to_run_phase",  32'(phase[0]), 32'd2);
        chk(1, "load_to_run_cpu_en", 32'(cpu_en[1]), 32'd1);
        if (done_on_last) begin
            cyc();
            cpu_done = 1'b0;
            chk(0, "run_entry_exit_phase",  32'(phase[0]), 32'd0);
            chk(0, "run_entry_exit_cpu_en", 32'(cpu_en[0]), 32'd0);
        end
    endtask

    task automatic do_run(input int n, input bit lit);
        int r;
        if (lit) begin
            cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
            settle();
            chk(0, "run_we",    32'(mif0.mem_we),    32'd1);
            chk(0, "run_addr",  32'(mif0.mem_addr),  32'h10);
            chk(1, "run_wdata", 32'(mif1.mem_wdata), 32'h5A);
            cyc();
        end
        for (int j = 0; j < n; j++) begin
            send = (j < 2);
            r = int'($urandom_range(3));
            cpu_we    = 1'($urandom_range(1));
            cpu_addr  = (r == 0) ? 16'(DBASE + int'($urandom_range(3))) :
                        (r == 1) ? 16'h0010 : 16'($urandom);
            cpu_wdata = 8'($urandom);
            rx_valid  = 1'($urandom_range(1));
            rx_data   = 8'($urandom);
            cyc();
        end
        send = 1'b0; rx_valid = 1'b0; cpu_we = 1'b0;
        cpu_done = 1'b1;
        cyc();
        cpu_done = 1'b0;
        chk(0, "run_exit_phase",  32'(phase[0]),  32'd0);
        chk(1, "run_exit_cpu_en", 32'(cpu_en[1]), 32'd0);
        chk(0, "run_send_ignored", 32'(tx_led[0]), 32'd0);
    endtask

    task automatic do_dump(input bit lit, input int stall_byte, input int stall_len);
        int n, stalls;
        send = 1'b1;
        cyc();
        send = 1'b0;
        for (int k = 0; k < DLEN; k++) begin
            n = 0;
            while (tx_valid[0] !== 1'b1 && n < 16) begin
                tx_ready = 1'($urandom_range(1));
                cyc();
                n++;
            end
            if (n >= 16) begin
                chk(0, "dump_wait_tx_valid", 32'(tx_valid[0]), 32'd1);
                break;
            end
            stalls = (k == stall_byte) ? stall_len : int'($urandom_range(2));
            tx_ready = 1'b0;
            for (int s = 0; s < stalls; s++) begin
                if (lit) chk(0, "dump_stall_data", 32'(tx_data[0]), 32'(init_byte(k)));
                cyc();
            end
            tx_ready = 1'b1;
            if (lit) chk(1, "dump_data", 32'(tx_data[1]), 32'(init_byte(k)));
            cyc();
            tx_ready = 1'b0;
        end
        chk(0, "dump_end_phase",    32'(phase[0]),    32'd0);
        chk(0, "dump_end_tx_valid", 32'(tx_valid[0]), 32'd0);
    endtask

    task automatic rand_bytes(output logic [7:0] b [4]);
        for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] b [4];
        int n;
        receive = 0; send = 0; rx_valid = 0; rx_data = 0; tx_ready = 0;
        cpu_done = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        repeat (3) cyc();
        chk(0, "reset_phase",    32'(phase[0]),    32'd0);
        chk(0, "reset_tx_valid", 32'(tx_valid[0]), 32'd0);
        chk(1, "reset_cpu_en",   32'(cpu_en[1]),   32'd0);
        rst_n = 1'b1;
        cyc();

        // dump of preloaded window with a 5-cycle stall on the second byte
        do_dump(1'b1, 1, 5);
        idle_junk(3);

        // load A1..D4, then run with a directed write
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        receive = 1'b1; cyc(); receive = 1'b0;
        load_body(b, 1'b1, 1'b0);
        do_run(12, 1'b1);

        // conflicting requests, rx in idle, cpu_done already high on run entry
        idle_junk(4);
        receive = 1'b1; send = 1'b1; cyc(); receive = 1'b0; send = 1'b0;
        chk(0, "both_edges_phase",  32'(phase[0]),  32'd1);
        chk(1, "both_edges_tx_LED", 32'(tx_led[1]), 32'd0);
        rand_bytes(b);
        load_body(b, 1'b0, 1'b1);
        idle_junk(2);
        do_dump(1'b0, -1, 0);

        // randomized phase sequences
        for (int it = 0; it < 10; it++) begin
            idle_junk(int'($urandom_range(1, 4)));
            if ($urandom_range(1) == 1) begin
                rand_bytes(b);
                receive = 1'b1; cyc(); receive = 1'b0;
                load_body(b, 1'b0, 1'b0);
                do_run(int'($urandom_range(3, 15)), 1'b0);
            end else begin
                do_dump(1'b0, int'($urandom_range(3)), int'($urandom_range(6)));
            end
        end

        // asynchronous reset while a byte is being offered
        send = 1'b1; cyc(); send = 1'b0;
        n = 0;
        while (tx_valid[0] !== 1'b1 && n < 16) begin tx_ready = 1'b0; cyc(); n++; end
        chk(0, "abort_pre_tx_valid", 32'(tx_valid[0]), 32'd1);
        rst_n = 1'b0;
        settle();
        chk(0, "abort_tx_valid", 32'(tx_valid[0]),   32'd0);
        chk(0, "abort_phase",    32'(phase[0]),      32'd0);
        chk(0, "abort_tx_data",  32'(tx_data[0]),    32'd0);
        chk(1, "abort_tx_LED",   32'(tx_led[1]),     32'd0);
        chk(1, "abort_mem_addr", 32'(mif1.mem_addr), 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        do_dump(1'b1, 0, 2);
        idle_junk(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end
endmodule
